// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver and its byte FIFO.
// The optional parity stage (UART_RX_PARITY_EN) uses the PARITY state defined here.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   localparam int OVERSAMPLE = 16;

   localparam logic [3:0] VOTE_LO  = 4'd7;
   localparam logic [3:0] VOTE_MID = 4'd8;
   localparam logic [3:0] VOTE_HI  = 4'd9;

   // Clocks per oversample tick; a too-slow clock still ticks every cycle.
   function automatic int calc_div(int clk_freq, int baud);
      int d;
      d = clk_freq / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake of the receive FIFO: show-ahead data, valid, pop and occupancy.
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             rd_en;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic [LVL_W-1:0] level;

   modport master (
      input  rd_en,
      output rd_data,
      output rd_valid,
      output level
   );

   modport slave (
      output rd_en,
      input  rd_data,
      input  rd_valid,
      input  level
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO: dout always presents the head entry; push while full
// is accepted only when a pop happens in the same cycle.
module uart_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];
   assign level   = count;

   // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling, 3-sample vote) feeding a show-ahead FIFO
// with sticky framing/overrun flags. Define UART_RX_PARITY_EN for even parity.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic rx,
   input  logic err_clr,
   output logic frame_err,
   output logic overrun,
`ifdef UART_RX_PARITY_EN
   output logic parity_err,
`endif
   uart_rx_fifo_if.master rd_if
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   rx_state_t  state;
   logic       rx_sync_p0;
   logic       rx_sync_p1;
   logic       rx_prev;
   logic [DIV_W-1:0] div_cnt;
   logic       tick;
   logic [3:0] smp_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       samp_lo;
   logic       samp_mid;
   logic       bit_val;
   logic       at_vote;
   logic       start_det;
   logic       push;
   logic       pop;
   logic       frame_set;
   logic       overrun_set;
   logic       fifo_full;
   logic       fifo_empty;
   logic       parity_bad;
   logic       parity_set;

   function automatic logic maj3(logic a, logic b, logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Stage p0/p1: two-flop synchroniser; rx_prev gives the edge reference.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_prev    <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
         rx_prev    <= rx_sync_p1;
      end
   end

   assign start_det = (state == IDLE) & rx_prev & ~rx_sync_p1;
   assign tick      = (div_cnt == DIV_W'(DIV - 1));
   assign at_vote   = tick & (smp_cnt == VOTE_HI);
   assign bit_val   = maj3(samp_lo, samp_mid, rx_sync_p1);
   assign pop       = rd_if.rd_en & rd_if.rd_valid;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)          div_cnt <= '0;
      else if (start_det) div_cnt <= '0;
      else if (tick)      div_cnt <= '0;
      else                div_cnt <= div_cnt + 1'b1;
   end

   always_comb begin
      push       = 1'b0;
      frame_set  = 1'b0;
      parity_set = 1'b0;
      if (at_vote) begin
         case (state)
            STOP: begin
               if (bit_val) push      = ~parity_bad;
               else         frame_set = 1'b1;
            end
            PARITY:  parity_set = (bit_val != ^shreg);
            default: ;
         endcase
      end
   end

   assign overrun_set = push & fifo_full & ~pop;

   // Vote samples and the shift register carry data only; no reset needed.
   always_ff @(posedge CLK) begin
      if (tick && smp_cnt == VOTE_LO)  samp_lo  <= rx_sync_p1;
      if (tick && smp_cnt == VOTE_MID) samp_mid <= rx_sync_p1;
      if (at_vote && state == DATA)    shreg    <= {bit_val, shreg[7:1]};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         smp_cnt    <= '0;
         bit_idx    <= '0;
         parity_bad <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err <= frame_set   | (frame_err & ~err_clr);
         overrun   <= overrun_set | (overrun   & ~err_clr);
         if (tick && state != IDLE && state != BREAK) smp_cnt <= smp_cnt + 4'd1;
         case (state)
            IDLE: begin
               if (start_det) begin
                  smp_cnt    <= '0;
                  parity_bad <= 1'b0;
                  state      <= START;
               end
            end
            START: begin
               if (at_vote) begin
                  bit_idx <= '0;
                  state   <= bit_val ? IDLE : DATA;
               end
            end
            DATA: begin
               if (at_vote) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_vote) begin
                  parity_bad <= parity_set;
                  state      <= STOP;
               end
            end
`endif
            // Leaving at mid-stop lets the next start edge resync the frame.
            STOP: begin
               if (at_vote) state <= bit_val ? IDLE : BREAK;
            end
            BREAK: begin
               if (rx_sync_p1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) parity_err <= 1'b0;
      else       parity_err <= parity_set | (parity_err & ~err_clr);
   end
`endif

   assign rd_if.rd_valid = ~fifo_empty;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push),
      .pop   (pop),
      .din   (shreg),
      .dout  (rd_if.rd_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (rd_if.level)
   );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Upstream stage feeding the CPU program loader; replaces the bare UART receiver.
- Receives 8N1 serial frames using 16x oversampling with a 3-sample majority vote.
- Buffers received bytes in a small show-ahead FIFO with a valid/pop handshake.
- Reports sticky framing-error and overrun flags so the loader can detect corrupt program downloads.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pop request; honoured only while rd_valid=1.
- err_clr  input  1  one-cycle pulse that clears frame_err and overrun.
- rd_data  output  8  FIFO head byte; valid while rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values:
  - State = IDLE; FIFO empty.
  - rd_valid=0, level=0, rd_data=0, frame_err=0, overrun=0.
  - Synchroniser flops = 1.
- Input path: rx passes through a 2-flop synchroniser before any use.
- Sample tick:
  - DIV = CLK_FREQ/(BAUD*16), integer division, minimum 1.
  - The divider counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - The divider is free-running, except that it is cleared on start-edge detection.
- Per-bit sampling:
  - A 4-bit sample counter counts ticks within each bit, 0..15.
  - The bit value is the majority of the samples taken at counts 7, 8 and 9; it is evaluated at count 9.
- States:
  - IDLE: on a 1->0 transition of synced rx, clear the divider and sample counter, then go to START.
  - START: at count 9, if the majority is 1 (glitch), return to IDLE; otherwise go to DATA with bit index 0.
  - DATA: at each count 9, shift the majority bit in LSB-first. After bit 7, go to STOP (or PARITY when the optional feature is enabled).
  - STOP, majority 1: push the byte into the FIFO, then go to IDLE. Returning half a bit early allows resync on the next start edge.
  - STOP, majority 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait until synced rx=1, then go to IDLE.
- FIFO (show-ahead):
  - rd_data always shows the head entry.
  - A pop occurs when rd_en && rd_valid; it takes effect at the next edge.
  - rd_en while empty is ignored.
- FIFO full and push:
  - Push while full without a simultaneous pop: the byte is dropped and overrun is set.
  - Push and pop in the same cycle while full: both succeed; level stays at FIFO_DEPTH; no overrun.
  - Push and pop in the same cycle while empty: not possible, since a pop needs rd_valid.
- Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH.
- Latency: the pushed byte is visible on rd_data/rd_valid one CLK after the mid-stop sample.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr coincides with a new error event, the flag being set wins.
- RESET asserted mid-frame: the partial frame is lost and the FIFO is flushed. On release the block stays in IDLE until a fresh falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - Even parity is sampled the same way as data bits.
  - On mismatch, the byte is discarded and the output parity_err (1 bit, sticky, reset 0, cleared by err_clr) is set.
  - The frame still proceeds to STOP, so framing is checked independently.
- When undefined: 8N1 only; no PARITY state and no parity_err port.

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum: IDLE, START, DATA, PARITY, STOP, BREAK;
  - OVERSAMPLE=16;
  - VOTE_LO=7, VOTE_MID=8, VOTE_HI=9.
- One natural sub-module: uart_byte_fifo (parameterised depth; push/pop/full/empty/level). The top keeps the synchroniser, tick generator and frame FSM.

Test Plan:
- Bench settings: CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 CLK per bit).
- Send 0xA5 (8N1), rd_en=0 -> rd_data=0xA5, rd_valid=1, level=1 one CLK after the mid-stop sample; both error flags stay 0.
- Send 0x12, 0x34, 0x56, 0x78, 0x9A with no pops -> level=4, overrun=1. Pops return 0x12, 0x34, 0x56, 0x78, then rd_valid=0.
- 3-CLK low glitch on an idle line -> no byte, state back in IDLE, level=0. A following 0x3C frame is received correctly.
- Frame 0x55 with stop bit held low, rx kept low for 40 CLK -> frame_err=1, level=0. After rx returns high, 0x0F is received. An err_clr pulse then gives frame_err=0.
- FIFO full plus 0xEE arriving while rd_en=1 in the push cycle -> no overrun, level=4, tail entry=0xEE.
- RESET pulse during bit 4 of a frame -> all outputs 0, FIFO empty. The next complete 0x81 is received correctly.
- UART_RX_PARITY_EN defined: 0x03 sent with parity bit 1 -> parity_err=1, byte discarded, level=0.
